step_cmd_gen: RTL and testbench



---
 rtl/step_cmd_gen_pkg.sv | 34 +++
 rtl/step_cmd_gen_if.sv | 16 +
 rtl/step_cmd_gen_btn_deb.sv | 46 ++++
 rtl/step_cmd_gen.sv | 119 +++++++++++
 tb/tb_step_cmd_gen.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/step_cmd_gen_pkg.sv
// Shared constants and step-pulse encoding for the front-panel step-command generator.
package stepgen_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] HOLD = 2'd1;
   localparam logic [1:0] RPT  = 2'd2;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   localparam logic [3:0] ACCEL_THR = 4'd8;
   localparam int         TMR_W     = 24;

   typedef struct packed {
      logic add1;
      logic add10;
      logic sub1;
      logic sub10;
   } step_t;

   function automatic step_t mk_step(input logic dir, input logic big);
      step_t s;
      s = '0;
      if (dir == DIR_UP) begin
         if (big) s.add10 = 1'b1;
         else     s.add1  = 1'b1;
      end else begin
         if (big) s.sub10 = 1'b1;
         else     s.sub1  = 1'b1;
      end
      return s;
   endfunction

endpackage

// File: rtl/step_cmd_gen_if.sv
// Board-side bundle: raw buttons/switch in, step pulses and HELD status out.
interface step_cmd_gen_if;
   logic BTN_UP;
   logic BTN_DN;
   logic SEL10;
   logic ADD1;
   logic ADD10;
   logic SUB1;
   logic SUB10;
   logic HELD;

   modport master (output BTN_UP, BTN_DN, SEL10,
                   input  ADD1, ADD10, SUB1, SUB10, HELD);
   modport slave  (input  BTN_UP, BTN_DN, SEL10,
                   output ADD1, ADD10, SUB1, SUB10, HELD);
endinterface

// File: rtl/step_cmd_gen_btn_deb.sv
// Two-flop synchroniser plus debounce counter; the level flips after DEB_CYC consecutive differing
// samples, and rise_o is a registered one-cycle strobe one clock after the level goes high.
module btn_deb #(
   parameter logic [15:0] DEB_CYC = 16'd50000
) (
   input  logic CLK,
   input  logic RST,
   input  logic raw_i,
   output logic lvl_o,
   output logic rise_o
);
   logic        s1_q, s2_q;
   logic        lvl_q, lvl_d, lvl_dly_q, rise_q;
   logic [15:0] cnt_q, cnt_d;

   // Counter only survives while the synced level keeps disagreeing.
   always_comb begin
      cnt_d = '0;
      lvl_d = lvl_q;
      if (s2_q != lvl_q) begin
         if (cnt_q == DEB_CYC - 16'd1) lvl_d = s2_q;
         else                          cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         lvl_q     <= 1'b0;
         lvl_dly_q <= 1'b0;
         rise_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         s1_q      <= raw_i;
         s2_q      <= s1_q;
         lvl_q     <= lvl_d;
         lvl_dly_q <= lvl_q;
         rise_q    <= lvl_q & ~lvl_dly_q;
         cnt_q     <= cnt_d;
      end
   end

   assign lvl_o  = lvl_q;
   assign rise_o = rise_q;
endmodule

// File: rtl/step_cmd_gen.sv
// Step-command generator: debounced up/down buttons drive one-cycle ADD/SUB pulses with hold-to-repeat.
// Define STEPGEN_ACCEL_EN to promote fine steps to coarse after ACCEL_THR repeat pulses in one hold.
module step_cmd_gen
   import stepgen_pkg::*;
#(
   parameter logic [15:0]      DEB_CYC = 16'd50000,
   parameter logic [TMR_W-1:0] RPT_DLY = 24'd5000000,
   parameter logic [TMR_W-1:0] RPT_PER = 24'd1000000
) (
   input logic           CLK,
   input logic           RST,
   step_cmd_gen_if.slave bus
);
   logic             up_lvl, up_rise, dn_lvl, dn_rise;
   logic             sel_s1_q, sel_s2_q;
   logic [1:0]       state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             dir_q, dir_d;
   step_t            out_q, out_d;
   logic             go_up, go_dn, fire, big, lat_lvl, oth_lvl, promote;

   btn_deb #(.DEB_CYC(DEB_CYC)) u_deb_up (
      .CLK(CLK), .RST(RST), .raw_i(bus.BTN_UP), .lvl_o(up_lvl), .rise_o(up_rise));
   btn_deb #(.DEB_CYC(DEB_CYC)) u_deb_dn (
      .CLK(CLK), .RST(RST), .raw_i(bus.BTN_DN), .lvl_o(dn_lvl), .rise_o(dn_rise));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sel_s1_q <= 1'b0;
         sel_s2_q <= 1'b0;
      end else begin
         sel_s1_q <= bus.SEL10;
         sel_s2_q <= sel_s1_q;
      end
   end

   assign lat_lvl = (dir_q == DIR_UP) ? up_lvl : dn_lvl;
   assign oth_lvl = (dir_q == DIR_UP) ? dn_lvl : up_lvl;

   // A rise only counts while the other button is debounced low, so both-pressed never fires.
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      dir_d   = dir_q;
      fire    = 1'b0;
      go_up   = up_rise & ~dn_lvl;
      go_dn   = dn_rise & ~up_lvl;
      case (state_q)
         IDLE: begin
            if (go_up ^ go_dn) begin
               fire    = 1'b1;
               dir_d   = go_up ? DIR_UP : DIR_DN;
               tmr_d   = RPT_DLY - 24'd1;
               state_d = HOLD;
            end
         end
         HOLD, RPT: begin
            if (!lat_lvl || oth_lvl) begin
               state_d = IDLE;
               tmr_d   = '0;
            end else if (tmr_q == '0) begin
               fire    = 1'b1;
               tmr_d   = RPT_PER - 24'd1;
               state_d = RPT;
            end else begin
               tmr_d   = tmr_q - 24'd1;
            end
         end
         default: begin
            state_d = IDLE;
            tmr_d   = '0;
         end
      endcase
   end

`ifdef STEPGEN_ACCEL_EN
   logic [3:0] rep_q, rep_d;

   assign promote = (rep_q >= ACCEL_THR);

   always_comb begin
      rep_d = rep_q;
      if (state_d == IDLE)
         rep_d = '0;
      else if (fire && state_q != IDLE && rep_q < ACCEL_THR)
         rep_d = rep_q + 4'd1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) rep_q <= '0;
      else     rep_q <= rep_d;
   end
`else
   assign promote = 1'b0;
`endif

   assign big   = sel_s2_q | promote;
   assign out_d = fire ? mk_step(dir_d, big) : '0;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         tmr_q   <= '0;
         dir_q   <= DIR_DN;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         dir_q   <= dir_d;
         out_q   <= out_d;
      end
   end

   assign bus.ADD1  = out_q.add1;
   assign bus.ADD10 = out_q.add10;
   assign bus.SUB1  = out_q.sub1;
   assign bus.SUB10 = out_q.sub10;
   assign bus.HELD  = (state_q != IDLE);
endmodule

// File: tb/tb_step_cmd_gen.sv
// Scoreboard bench for step_cmd_gen: a window-based debounce / hold-timer reference model predicts
// every pulse and the HELD level; a negedge monitor pops and compares.
module tb_step_cmd_gen;
   localparam int D   = 4;
   localparam int DLY = 20;
   localparam int PER = 5;
   localparam int HN  = 8192;
`ifdef STEPGEN_ACCEL_EN
   localparam bit ACCEL = 1'b1;
`else
   localparam bit ACCEL = 1'b0;
`endif

   logic CLK = 1'b0;
   logic RST = 1'b1;

   step_cmd_gen_if bus();

   step_cmd_gen #(.DEB_CYC(16'd4), .RPT_DLY(24'd20), .RPT_PER(24'd5)) dut (
      .CLK(CLK), .RST(RST), .bus(bus));

   always #5 CLK = ~CLK;

   typedef struct { int cyc; int kind; } exp_t;  // kind: 0 ADD1, 1 ADD10, 2 SUB1, 3 SUB10
   exp_t q[$];

   bit  up_h[HN], dn_h[HN], sel_h[HN];
   int  n_chk = 0, n_err = 0;
   int  cur_edge = -1;
   bit  exp_held = 1'b0;

   function automatic bit samp(input int w, input int kk);
      if (kk < 0) return 1'b0;
      case (w)
         0:       return up_h[kk % HN];
         1:       return dn_h[kk % HN];
         default: return sel_h[kk % HN];
      endcase
   endfunction

   // Level flips at edge kk if the raw samples seen by the debouncer for the last D cycles all differ.
   function automatic bit flips(input int w, input bit lvl, input int kk);
      for (int j = kk - 1 - D; j <= kk - 2; j++)
         if (samp(w, j) == lvl) return 1'b0;
      return 1'b1;
   endfunction

   // Reference model
   initial begin
      int  k, up_rise, dn_rise, nxt, rep, kind;
      bit  m_up, m_dn, hold, dir, r_up, r_dn, gu, gd, fire, big;
      k = 0; m_up = 0; m_dn = 0; up_rise = -10; dn_rise = -10; hold = 0; dir = 0; nxt = 0; rep = 0;
      forever begin
         @(posedge CLK or posedge RST);
         if (RST) begin
            k = 0; m_up = 0; m_dn = 0; up_rise = -10; dn_rise = -10; hold = 0; rep = 0;
            exp_held = 1'b0; cur_edge = -1;
            q.delete();
         end else begin
            up_h[k % HN]  = bus.BTN_UP;
            dn_h[k % HN]  = bus.BTN_DN;
            sel_h[k % HN] = bus.SEL10;
            r_up = (up_rise == k - 2);
            r_dn = (dn_rise == k - 2);
            fire = 1'b0;
            big  = samp(2, k - 2);
            if (!hold) begin
               gu = r_up && !m_dn;
               gd = r_dn && !m_up;
               if (gu != gd) begin
                  hold = 1; dir = gu; nxt = k + DLY; rep = 0; fire = 1;
               end
            end else if (!(dir ? m_up : m_dn) || (dir ? m_dn : m_up)) begin
               hold = 0;
            end else if (k == nxt) begin
               fire = 1; nxt = k + PER;
               if (ACCEL && rep >= 8) big = 1'b1;
               rep++;
            end
            if (fire) begin
               kind = (dir ? 0 : 2) + (big ? 1 : 0);
               q.push_back('{cyc: k, kind: kind});
            end
            if (flips(0, m_up, k)) begin m_up = !m_up; if (m_up) up_rise = k; end
            if (flips(1, m_dn, k)) begin m_dn = !m_dn; if (m_dn) dn_rise = k; end
            exp_held = hold;
            cur_edge = k;
            k++;
         end
      end
   end

   // Monitor
   initial begin
      int   np, got;
      exp_t e;
      forever begin
         @(negedge CLK);
         np  = int'(bus.ADD1) + int'(bus.ADD10) + int'(bus.SUB1) + int'(bus.SUB10);
         got = bus.ADD1 ? 0 : bus.ADD10 ? 1 : bus.SUB1 ? 2 : bus.SUB10 ? 3 : -1;
         n_chk++;
         if (np > 1) begin
            n_err++;
            $display("FAIL onehot edge %0d: %0d pulses high, want at most 1", cur_edge, np);
         end
         if (q.size() > 0 && q[0].cyc == cur_edge) begin
            e = q.pop_front();
            n_chk++;
            if (np != 1 || got != e.kind) begin
               n_err++;
               $display("FAIL pulse edge %0d: got kind %0d, want kind %0d", cur_edge, got, e.kind);
            end
         end else begin
            n_chk++;
            if (np != 0) begin
               n_err++;
               $display("FAIL spurious edge %0d: got kind %0d, want none", cur_edge, got);
            end
         end
         n_chk++;
         if (bus.HELD !== exp_held) begin
            n_err++;
            $display("FAIL held edge %0d: got %b, want %b", cur_edge, bus.HELD, exp_held);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic drive(input bit u, input bit d, input bit s);
      bus.BTN_UP = u;
      bus.BTN_DN = d;
      bus.SEL10  = s;
   endtask

   task automatic check_quiet(input string name);
      logic [4:0] o;
      o = {bus.ADD1, bus.ADD10, bus.SUB1, bus.SUB10, bus.HELD};
      n_chk++;
      if (o !== 5'b0) begin
         n_err++;
         $display("FAIL %s: outputs %b, want 00000", name, o);
      end
   endtask

   initial begin
      bit u, d, s;
      drive(0, 0, 0);
      #12;
      check_quiet("reset_state");
      @(posedge CLK); #2 RST = 1'b0;

      // clean press, fine step
      tick(3);
      drive(1, 0, 0); tick(10);
      drive(0, 0, 0); tick(20);

      // bouncing down button, then steady
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 0); tick(2);
         drive(0, 0, 0); tick(2);
      end
      drive(0, 1, 0); tick(8);
      drive(0, 0, 0); tick(20);

      // auto-repeat, coarse step
      drive(1, 0, 1); tick(60);
      drive(0, 0, 0); tick(20);

      // abort by pressing the other button, then re-arm
      drive(1, 0, 0); tick(35);
      drive(1, 1, 0); tick(15);
      drive(0, 1, 0); tick(15);
      drive(0, 0, 0); tick(15);
      drive(0, 1, 0); tick(12);
      drive(0, 0, 0); tick(15);

      // asynchronous reset in the middle of repeat
      drive(1, 0, 0); tick(40);
      #2 RST = 1'b1;
      #1 check_quiet("async_reset");
      @(posedge CLK); #2 RST = 1'b0;
      tick(20);
      drive(0, 0, 0); tick(20);

      // long fine hold on down (acceleration when enabled)
      drive(0, 1, 0); tick(110);
      drive(0, 0, 0); tick(20);

      // randomized segments, including mid-hold SEL10 changes and overlaps
      for (int i = 0; i < 40; i++) begin
         u = ($urandom_range(0, 2) != 0);
         d = ($urandom_range(0, 3) == 0);
         s = $urandom_range(0, 1);
         drive(u, d, s);
         tick($urandom_range(1, 45));
         if ($urandom_range(0, 3) == 0) begin
            bus.SEL10 = ~bus.SEL10;
            tick($urandom_range(1, 15));
         end
      end
      drive(0, 0, 0); tick(30);

      n_chk++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expected pulses never seen, want 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
